// File: rtl/seq_control_unit.sv
// Multi-cycle control sequencer: accepts one opcode per handshake and steps it through
// DECODE/EXEC/MEM/WB, driving datapath enables from registered state with a memory timeout.
module seq_control_unit #(
  parameter int OPCODE_W    = 5,
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_en,
  output logic                  reg_re,
  output logic                  reg_we,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  localparam logic [OPCODE_W-1:0] OP_NOP    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ALU_LO = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ALU_HI = OPCODE_W'(9);

  localparam logic [ALU_CTRL_W-1:0] ALU_IDLE = {ALU_CTRL_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  logic [2:0]            state_r, state_s;
  logic [OPCODE_W-1:0]   opcode_r, opcode_s;
  logic [WAIT_W-1:0]     wait_r, wait_s;
  logic                  accept_s, set_illegal_s, set_timeout_s, is_alu_s;
  logic                  err_illegal_r, err_timeout_r;
  logic [CNT_W-1:0]      count_r;

  logic                  instr_ready_r, alu_en_r, reg_re_r, reg_we_r, mem_re_r, mem_we_r, done_r;
  logic                  instr_ready_s, alu_en_s, reg_re_s, reg_we_s, mem_re_s, mem_we_s, done_s;
  logic [ALU_CTRL_W-1:0] alu_ctrl_r, alu_ctrl_s;

  assign accept_s = instr_valid & instr_ready_r;

  // Next-state, opcode latch and memory wait counter.
  always_comb begin
    state_s       = state_r;
    opcode_s      = opcode_r;
    wait_s        = wait_r;
    set_illegal_s = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          opcode_s = opcode;
          state_s  = ST_DECODE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if ((opcode_r >= OP_ALU_LO) && (opcode_r <= OP_ALU_HI)) begin
          state_s = ST_EXEC;
        end else if ((opcode_r == OP_LOAD) || (opcode_r == OP_STORE)) begin
          state_s = ST_MEM;
        end else if (opcode_r == OP_NOP) begin
          state_s = ST_DONE;
        end else begin
          state_s       = ST_DONE;
          set_illegal_s = 1'b1;
        end
      end
      ST_EXEC: state_s = ST_WB;
      ST_MEM: begin
        // A response in the last allowed cycle takes priority over the timeout.
        if (mem_ready) begin
          wait_s  = WAIT_ZERO;
          state_s = (opcode_r == OP_LOAD) ? ST_WB : ST_DONE;
        end else if (wait_r == WAIT_LAST) begin
          wait_s        = WAIT_ZERO;
          state_s       = ST_DONE;
          set_timeout_s = 1'b1;
        end else begin
          wait_s = wait_r + WAIT_ONE;
        end
      end
      ST_WB:   state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        wait_s  = WAIT_ZERO;
      end
    endcase
  end

  assign is_alu_s = (opcode_s >= OP_ALU_LO) && (opcode_s <= OP_ALU_HI);

  // Output decode of the upcoming state, registered so outputs track state_r exactly.
  always_comb begin
    instr_ready_s = 1'b0;
    alu_en_s      = 1'b0;
    reg_re_s      = 1'b0;
    reg_we_s      = 1'b0;
    mem_re_s      = 1'b0;
    mem_we_s      = 1'b0;
    done_s        = 1'b0;
    alu_ctrl_s    = ALU_IDLE;
    case (state_s)
      ST_IDLE:   instr_ready_s = 1'b1;
      ST_DECODE: reg_re_s = is_alu_s || (opcode_s == OP_LOAD) || (opcode_s == OP_STORE);
      ST_EXEC: begin
        alu_en_s   = 1'b1;
        reg_re_s   = 1'b1;
        alu_ctrl_s = ALU_CTRL_W'(opcode_s - OP_ALU_LO);
      end
      ST_MEM: begin
        mem_re_s = (opcode_s == OP_LOAD);
        mem_we_s = (opcode_s == OP_STORE);
      end
      ST_WB:   reg_we_s = 1'b1;
      ST_DONE: done_s   = 1'b1;
      default: instr_ready_s = 1'b0;
    endcase
  end

  // State, latched opcode and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      opcode_r <= OP_NOP;
      wait_r   <= WAIT_ZERO;
    end else begin
      state_r  <= state_s;
      opcode_r <= opcode_s;
      wait_r   <= wait_s;
    end
  end

  // Error flags: cleared on accept, set on the failing transition, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal_r <= 1'b0;
      err_timeout_r <= 1'b0;
    end else if (accept_s) begin
      err_illegal_r <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      err_illegal_r <= err_illegal_r | set_illegal_s;
      err_timeout_r <= err_timeout_r | set_timeout_s;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if ((state_r == ST_DONE) && !err_illegal_r && !err_timeout_r) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // Registered datapath control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ready_r <= 1'b0;
      alu_en_r      <= 1'b0;
      reg_re_r      <= 1'b0;
      reg_we_r      <= 1'b0;
      mem_re_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      done_r        <= 1'b0;
      alu_ctrl_r    <= ALU_IDLE;
    end else begin
      instr_ready_r <= instr_ready_s;
      alu_en_r      <= alu_en_s;
      reg_re_r      <= reg_re_s;
      reg_we_r      <= reg_we_s;
      mem_re_r      <= mem_re_s;
      mem_we_r      <= mem_we_s;
      done_r        <= done_s;
      alu_ctrl_r    <= alu_ctrl_s;
    end
  end

  assign instr_ready = instr_ready_r;
  assign alu_en      = alu_en_r;
  assign reg_re      = reg_re_r;
  assign reg_we      = reg_we_r;
  assign mem_re      = mem_re_r;
  assign mem_we      = mem_we_r;
  assign done        = done_r;
  assign alu_ctrl    = alu_ctrl_r;
  assign err_illegal = err_illegal_r;
  assign err_timeout = err_timeout_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized self-checking bench for seq_control_unit against a per-instruction
// latency/enable-count model derived from the opcode rules.
module tb_seq_control_unit;

  localparam int T   = 15;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [4:0]    opcode;
  logic          mem_ready;
  logic [3:0]    alu_ctrl;
  logic          alu_en, reg_re, reg_we, mem_re, mem_we, done;
  logic          err_illegal, err_timeout;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  seq_control_unit #(.OPCODE_W(5), .ALU_CTRL_W(4), .MEM_TIMEOUT(T), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .mem_ready(mem_ready), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
    .reg_re(reg_re), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .done(done),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one instruction; ready_at = MEM cycle carrying mem_ready, 0 = never.
  task automatic run_instr(input logic [4:0] op, input int ready_at, input int gap);
    int exp_lat = 2, exp_alu = 0, exp_rre = 0, exp_rwe = 0, exp_mre = 0, exp_mwe = 0;
    int exp_ctrl = 15, k;
    bit exp_il = (op > 5'd9), exp_to = 1'b0;
    int n_alu = 0, n_rre = 0, n_rwe = 0, n_mre = 0, n_mwe = 0;
    int done_at = 0, mem_cnt = 0, bad_hot = 0, bad_ctrl = 0, ctrl_seen = 15, c = 1;

    if (!exp_il && op >= 5'd3) begin
      exp_lat = 4; exp_alu = 1; exp_rre = 2; exp_rwe = 1; exp_ctrl = int'(op) - 3;
    end else if (op == 5'd1 || op == 5'd2) begin
      exp_to  = (ready_at == 0);
      k       = exp_to ? T : ready_at;
      exp_rre = 1;
      if (op == 5'd1) begin
        exp_mre = k; exp_rwe = exp_to ? 0 : 1; exp_lat = 2 + k + exp_rwe;
      end else begin
        exp_mwe = k; exp_lat = 2 + k;
      end
    end

    repeat (gap) begin
      instr_valid = 1'b0; opcode = 5'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b1; opcode = op; mem_ready = 1'($urandom);
    chk("ready_at_issue", int'(instr_ready), 1);
    @(negedge clk);

    while (c <= 60 && done_at == 0) begin
      if (c == 1) begin
        chk("ready_busy", int'(instr_ready), 0);
        chk("err_il_cleared", int'(err_illegal), 0);
        chk("err_to_cleared", int'(err_timeout), 0);
      end
      n_alu += int'(alu_en); n_rre += int'(reg_re); n_rwe += int'(reg_we);
      n_mre += int'(mem_re); n_mwe += int'(mem_we);
      if (int'(alu_en) + int'(reg_we) + int'(mem_re) + int'(mem_we) > 1) bad_hot++;
      if (alu_en) ctrl_seen = int'(alu_ctrl);
      else if (alu_ctrl !== 4'hF) bad_ctrl++;
      opcode = 5'($urandom);
      if (mem_re || mem_we) begin
        mem_cnt++;
        mem_ready = (mem_cnt == ready_at);
      end else begin
        mem_ready = 1'($urandom);
      end
      if (done) begin
        done_at = c;
        chk("err_illegal", int'(err_illegal), int'(exp_il));
        chk("err_timeout", int'(err_timeout), int'(exp_to));
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
      end
      c++;
      @(negedge clk);
    end

    if (!exp_il && !exp_to) model_count = (model_count + 1) % (1 << CW);
    chk("latency", done_at, exp_lat);
    chk("alu_en_cycles", n_alu, exp_alu);
    chk("reg_re_cycles", n_rre, exp_rre);
    chk("reg_we_cycles", n_rwe, exp_rwe);
    chk("mem_re_cycles", n_mre, exp_mre);
    chk("mem_we_cycles", n_mwe, exp_mwe);
    chk("alu_ctrl_exec", ctrl_seen, exp_ctrl);
    chk("onehot", bad_hot, 0);
    chk("alu_ctrl_idle", bad_ctrl, 0);
    chk("done_pulse", int'(done), 0);
    chk("ready_after", int'(instr_ready), 1);
    chk("flag_hold_il", int'(err_illegal), int'(exp_il));
    chk("flag_hold_to", int'(err_timeout), int'(exp_to));
    chk("instr_count", int'(instr_count), model_count);
  endtask

  initial begin
    int r, op, ra;
    bit seen_done;
    rst_n = 1'b0; instr_valid = 1'b1; opcode = 5'd3; mem_ready = 1'b0;
    #12;
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_alu_ctrl", int'(alu_ctrl), 15);
    chk("rst_count", int'(instr_count), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b1;

    // Directed scenarios
    run_instr(5'd3, 0, 2);
    run_instr(5'd1, 3, 1);
    run_instr(5'd2, 0, 0);
    run_instr(5'd31, 0, 1);
    run_instr(5'd0, 0, 0);
    run_instr(5'd1, T, 1);
    run_instr(5'd2, T, 0);
    run_instr(5'd1, 0, 0);
    run_instr(5'd2, 1, 2);
    for (int i = 0; i < 16; i++) run_instr(5'd0, 0, 0);
    run_instr(5'd9, 0, 0);

    // Randomized instructions
    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 11);
      op = (r > 9) ? $urandom_range(10, 31) : r;
      ra = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, T);
      run_instr(5'(op), ra, $urandom_range(0, 3));
    end

    // Reset during MEM of a LOAD
    instr_valid = 1'b1; opcode = 5'd1; mem_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mem_re_before_rst", int'(mem_re), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_re", int'(mem_re), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_ready", int'(instr_ready), 0);
    chk("rst_mid_ctrl", int'(alu_ctrl), 15);
    chk("rst_mid_count", int'(instr_count), 0);
    model_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("no_done_after_rst", int'(seen_done), 0);
    chk("ready_after_rst", int'(instr_ready), 1);
    run_instr(5'd4, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
